// File: rtl/alu_ctrl_pkg.sv
// ALU control pipeline: shared ALUop/funct constants, control codes, FSM states.
// Imported by alu_ctrl_decode and alu_ctrl_pipe.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;

    localparam logic [5:0] FN_OP0 = 6'b100111;
    localparam logic [5:0] FN_OP4 = 6'b111111;
    localparam logic [5:0] FN_MUL = 6'b011000;

    localparam logic [3:0] CTL_0000 = 4'b0000;
    localparam logic [3:0] CTL_0001 = 4'b0001;
    localparam logic [3:0] CTL_0010 = 4'b0010;
    localparam logic [3:0] CTL_0011 = 4'b0011;
    localparam logic [3:0] CTL_0100 = 4'b0100;
    localparam logic [3:0] CTL_MUL  = 4'b0101;
    localparam logic [3:0] CTL_NOP  = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_MULTI
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU control decoder: maps (ALUop, funct) to control word,
// multi-cycle flag and unknown-funct flag. Purely combinational.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] funct,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_multi,
    output logic              is_illegal
);

    // Decode table; every ALUop/funct pair yields a defined word.
    always_comb begin
        ctrl       = CTRL_W'(CTL_NOP);
        is_multi   = 1'b0;
        is_illegal = 1'b0;
        unique case (1'b1)
            (alu_op == ALUOP_RTYPE): begin
                if (funct == FUNC_W'(FN_OP0)) begin
                    ctrl = CTRL_W'(CTL_0000);
                end else if (funct == FUNC_W'(FN_OP4)) begin
                    ctrl = CTRL_W'(CTL_0100);
                end else if (funct == FUNC_W'(FN_MUL)) begin
                    ctrl     = CTRL_W'(CTL_MUL);
                    is_multi = 1'b1;
                end else begin
                    is_illegal = 1'b1;
                end
            end
            (alu_op == ALUOP_IMM): ctrl = CTRL_W'(CTL_0001);
            (alu_op == ALUOP_MEM): ctrl = CTRL_W'(CTL_0010);
            (alu_op == ALUOP_BR):  ctrl = CTRL_W'(CTL_0011);
            default:               ctrl = CTRL_W'(CTL_NOP);
        endcase
    end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ID/EX ALU control register with multi-cycle MUL occupancy and busy.
// Optional macro ALU_CTRL_ILLEGAL_EN enables the registered illegal flag.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W  = 6,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        alu_op_in,
    input  logic [FUNC_W-1:0] function_code,
    input  logic              stall_in,
    input  logic              flush,
    output logic [CTRL_W-1:0] alu_control,
    output logic              ctrl_valid,
    output logic              busy,
    output logic              illegal
);

    localparam int LOAD_I = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
    localparam logic [3:0] CNT_LOAD = LOAD_I[3:0];

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_multi;
    logic              dec_illegal;
    logic              accept;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              valid_d;
    logic              busy_d;

    alu_ctrl_decode #(
        .FUNC_W (FUNC_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .alu_op     (alu_op_in),
        .funct      (function_code),
        .ctrl       (dec_ctrl),
        .is_multi   (dec_multi),
        .is_illegal (dec_illegal)
    );

    assign accept = in_valid && !stall_in && !flush
                    && (state_q == ST_IDLE);

    // Next state: flush wins, stall freezes, MULTI ignores inputs.
    // On leaving MULTI ctrl_valid stays up for the MUL's final cycle,
    // so the slot can be refilled back-to-back once busy has fallen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = alu_control;
        valid_d = ctrl_valid;
        busy_d  = busy;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            ctrl_d  = CTRL_W'(CTL_NOP);
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else if (!stall_in) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ctrl_d  = dec_ctrl;
                        valid_d = 1'b1;
                        if (dec_multi && (MUL_LAT > 1)) begin
                            state_d = ST_MULTI;
                            cnt_d   = CNT_LOAD;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                ST_MULTI: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter and ID/EX control field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            alu_control <= CTRL_W'(CTL_NOP);
            ctrl_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_control <= ctrl_d;
            ctrl_valid  <= valid_d;
            busy        <= busy_d;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    logic illegal_seen;

    // Illegal flag tracks the last accept; illegal_seen is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal      <= 1'b0;
            illegal_seen <= 1'b0;
        end else if (flush) begin
            illegal <= 1'b0;
        end else if (accept) begin
            illegal      <= dec_illegal;
            illegal_seen <= illegal_seen | dec_illegal;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed cases plus random
// traffic against a slot-occupancy reference model.
module tb_alu_ctrl_pipe;

    localparam int FUNC_W  = 6;
    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [1:0]        alu_op_in = 2'b00;
    logic [FUNC_W-1:0] function_code = '0;
    logic              stall_in = 1'b0;
    logic              flush = 1'b0;
    logic [CTRL_W-1:0] alu_control;
    logic              ctrl_valid;
    logic              busy;
    logic              illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_ctrl;
    logic       m_valid;
    logic       m_busy;
    logic       m_ill;
    logic       m_seen;
    int         m_rem;

    alu_ctrl_pipe #(
        .FUNC_W  (FUNC_W),
        .CTRL_W  (CTRL_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .alu_op_in     (alu_op_in),
        .function_code (function_code),
        .stall_in      (stall_in),
        .flush         (flush),
        .alu_control   (alu_control),
        .ctrl_valid    (ctrl_valid),
        .busy          (busy),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_code(input logic [1:0] op,
                                            input logic [5:0] fn);
        case (op)
            2'b11: return 4'b0001;
            2'b00: return 4'b0010;
            2'b01: return 4'b0011;
            default: begin
                case (fn)
                    6'b100111: return 4'b0000;
                    6'b111111: return 4'b0100;
                    6'b011000: return 4'b0101;
                    default:   return 4'b1111;
                endcase
            end
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl  = 4'b1111;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_ill   = 1'b0;
        m_seen  = 1'b0;
        m_rem   = 0;
    endtask

    // m_rem = EX cycles still owned by the current instruction.
    task automatic model_edge();
        logic is_mul;
        logic is_ill;
        is_mul = (alu_op_in == 2'b10) && (function_code == 6'b011000);
        is_ill = (alu_op_in == 2'b10)
                 && (ref_code(alu_op_in, function_code) == 4'b1111);
        if (flush) begin
            m_ctrl  = 4'b1111;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_rem   = 0;
            m_ill   = 1'b0;
        end else if (!stall_in) begin
            if (m_rem > 1) begin
                m_rem  = m_rem - 1;
                m_busy = (m_rem > 1);
            end else if (in_valid) begin
                m_ctrl  = ref_code(alu_op_in, function_code);
                m_valid = 1'b1;
                m_rem   = is_mul ? MUL_LAT : 1;
                m_busy  = (m_rem > 1);
                m_ill   = is_ill;
                m_seen  = m_seen | is_ill;
            end else begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                m_rem   = 0;
            end
        end
    endtask

    task automatic check_outputs(input string where);
        logic exp_ill;
`ifdef ALU_CTRL_ILLEGAL_EN
        exp_ill = m_ill;
        chk({where, ".illegal_seen"}, 32'(dut.illegal_seen), 32'(m_seen));
`else
        exp_ill = 1'b0;
`endif
        chk({where, ".alu_control"}, 32'(alu_control), 32'(m_ctrl));
        chk({where, ".ctrl_valid"}, 32'(ctrl_valid), 32'(m_valid));
        chk({where, ".busy"}, 32'(busy), 32'(m_busy));
        chk({where, ".illegal"}, 32'(illegal), 32'(exp_ill));
    endtask

    task automatic drv(input logic v, input logic [1:0] op,
                       input logic [5:0] fn, input logic st,
                       input logic fl);
        in_valid      = v;
        alu_op_in     = op;
        function_code = fn;
        stall_in      = st;
        flush         = fl;
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(where);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back single-cycle ops
        drv(1, 2'b10, 6'b100111, 0, 0); step("op0000");
        drv(1, 2'b10, 6'b111111, 0, 0); step("op0100");
        drv(1, 2'b11, 6'b000000, 0, 0); step("op0001");
        drv(1, 2'b00, 6'b000000, 0, 0); step("op0010");
        drv(1, 2'b01, 6'b000000, 0, 0); step("op0011");
        drv(0, 2'b00, 6'b000000, 0, 0); step("idle");

        // MUL, with an ALUop=11 presented throughout the occupancy
        drv(1, 2'b10, 6'b011000, 0, 0); step("mul_c1");
        drv(1, 2'b11, 6'b000000, 0, 0); step("mul_c2");
        step("mul_c3");
        step("after_mul");
        drv(0, 2'b00, 6'b000000, 0, 0); step("idle2");

        // Stall for two cycles mid-MUL
        drv(1, 2'b10, 6'b011000, 0, 0); step("smul_c1");
        drv(0, 2'b00, 6'b000000, 1, 0); step("smul_st1");
        step("smul_st2");
        drv(0, 2'b00, 6'b000000, 0, 0); step("smul_c2");
        step("smul_c3");
        step("smul_end");

        // Flush during MULTI with a presented instruction
        drv(1, 2'b10, 6'b011000, 0, 0); step("fmul_c1");
        drv(1, 2'b11, 6'b000000, 0, 1); step("flush");
        drv(0, 2'b00, 6'b000000, 0, 0); step("post_flush");

        // Unknown funct, then a legal op
        drv(1, 2'b10, 6'b000001, 0, 0); step("illegal");
        drv(1, 2'b00, 6'b000000, 0, 0); step("legal_after");
        drv(0, 2'b00, 6'b000000, 0, 0); step("idle3");

        // Asynchronous reset while busy
        drv(1, 2'b10, 6'b011000, 0, 0); step("rmul_c1");
        drv(0, 2'b00, 6'b000000, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [5:0] fn;
            case ($urandom_range(0, 5))
                0: fn = 6'b100111;
                1: fn = 6'b111111;
                2, 3: fn = 6'b011000;
                default: fn = 6'($urandom);
            endcase
            drv($urandom_range(0, 3) != 0, 2'($urandom), fn,
                $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
